simon_arbiter: RTL and testbench
================================

SIMON_ARBITER -- requirements
Module: simon_arbiter

Interface
REQ-001 Parameter N, default 16, word width.
REQ-002 Parameter M, default 4, key words.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 R  input  1  reset; synchronous, active-high.
REQ-005 reqValid  input  2  per-requester job request; index 0/1.
REQ-006 reqEncDec  input  2  per-requester mode; 1 encrypt, 0 decrypt.
REQ-007 reqKey  input  2x[M][N]  per-requester key.
REQ-008 reqBlock  input  2x[2][N]  per-requester plaintext/ciphertext.
REQ-009 reqAccept  output  2  one-hot pulse; job captured.
REQ-010 rspValid  output  2  one-hot; result held on rspData.
REQ-011 rspReady  input  2  requester consumes result.
REQ-012 rspData  output  [2][N]  result block.
REQ-013 newKey, newData, enc_dec, readData  output  1 each  core controls.
REQ-014 KEY  output  [M][N]; blockIN  output  [2][N]  core operands.
REQ-015 loadKey, loadData, doneKey, doneData  input  1 each  core status.
REQ-016 outData  input  [2][N]  core result.

Function
REQ-017 Shares one SIMON_3264 core between two requesters; one job in flight at a time.
REQ-018 FSM states IDLE, GRANT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, RESP.
REQ-019 IDLE: any reqValid -> GRANT next cycle; none -> stay.
REQ-020 GRANT: round-robin pick; requester != lastGrant wins ties; reqAccept[winner] pulses 1 cycle; reqKey, reqEncDec, reqBlock latched same edge.
REQ-021 GRANT: latched key == keyCache and cacheValid -> DATA_REQ; else KEY_REQ.
REQ-022 KEY_REQ: KEY driven from latch; newKey held high until loadKey sampled high, then -> KEY_WAIT.
REQ-023 KEY_WAIT: doneKey high -> keyCache <= latched key, cacheValid <= 1, -> DATA_REQ.
REQ-024 DATA_REQ: blockIN and enc_dec driven from latch; newData high until loadData sampled high, then -> DATA_WAIT.
REQ-025 DATA_WAIT: doneData high -> outData captured into rspData, -> RESP.
REQ-026 RESP: rspValid[owner] high, rspData stable, until rspReady[owner]; that cycle readData pulses 1 cycle, lastGrant <= owner, -> IDLE.
REQ-027 enc_dec, KEY, blockIN held constant from GRANT exit until RESP exit.
REQ-028 reqValid deasserted after reqAccept ignored; reqValid during own in-flight job queued as new request.
REQ-029 rspReady of non-owner ignored; rspValid never high for both.
REQ-030 Minimum latency reqValid -> reqAccept 2 cycles (IDLE, GRANT).
REQ-031 Back-to-back same key: second job issues no newKey pulse.
REQ-032 doneKey/doneData outside their wait states ignored.

Reset
REQ-033 R high: state IDLE; lastGrant 1 (requester 0 wins first); cacheValid 0; reqAccept, rspValid, newKey, newData, readData 0; rspData 0.
REQ-034 R mid-job: job discarded, no rspValid; next key always reloaded (cacheValid 0).

Structure
REQ-035 Shared package simon_pkg: state enum, N/M defaults, requester count constant 2.
REQ-036 Sub-module simon_rr_picker: combinational 2-way round-robin from reqValid and lastGrant.
REQ-037 Core instantiated outside block; block connects only via REQ-013..016.

Verification
REQ-038 Reset, reqValid=2'b11 -> reqAccept=2'b01 second cycle; subsequent grant 2'b10.
REQ-039 Requester 0 encrypt key 0x1918_1110_0908_0100, block 0x6565_6877 -> rspData 0xc69b_e9bb via core model.
REQ-040 Two jobs same key -> exactly one newKey burst; two newData bursts.
REQ-041 rspReady held low 20 cycles -> rspValid and rspData stable; readData 0 until ready.
REQ-042 R pulse during DATA_WAIT -> no rspValid; next job re-issues newKey.
REQ-043 Alternating keys both requesters, continuous reqValid -> grants alternate 0,1,0,1; newKey every job.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the two-requester SIMON core arbiter: default widths,
// requester count and the job-sequencing state encoding.
package simon_pkg;

    localparam int N_DEFAULT   = 16;
    localparam int M_DEFAULT   = 4;
    localparam int NUM_REQ     = 2;
    localparam int BLOCK_WORDS = 2;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        KEY_REQ,
        KEY_WAIT,
        DATA_REQ,
        DATA_WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/simon_rr_picker.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to the requester that was not served last.
module simon_rr_picker
    import simon_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_last_grant,
    output logic               o_grant_valid,
    output logic               o_grant_idx
);

    always_comb begin
        o_grant_valid = |i_req_valid;
        o_grant_idx   = 1'b0;
        if (&i_req_valid) begin
            o_grant_idx = ~i_last_grant;
        end else if (i_req_valid[1]) begin
            o_grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/simon_arbiter.sv
// Shares one external SIMON core between two requesters, one job at a time,
// skipping the key expansion when the granted key matches the last loaded key.
module simon_arbiter
    import simon_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        R,
    input  logic [NUM_REQ-1:0]                          reqValid,
    input  logic [NUM_REQ-1:0]                          reqEncDec,
    input  logic [NUM_REQ-1:0][M-1:0][N-1:0]            reqKey,
    input  logic [NUM_REQ-1:0][BLOCK_WORDS-1:0][N-1:0]  reqBlock,
    output logic [NUM_REQ-1:0]                          reqAccept,
    output logic [NUM_REQ-1:0]                          rspValid,
    input  logic [NUM_REQ-1:0]                          rspReady,
    output logic [BLOCK_WORDS-1:0][N-1:0]               rspData,
    output logic                                        newKey,
    output logic                                        newData,
    output logic                                        enc_dec,
    output logic                                        readData,
    output logic [M-1:0][N-1:0]                         KEY,
    output logic [BLOCK_WORDS-1:0][N-1:0]               blockIN,
    input  logic                                        loadKey,
    input  logic                                        loadData,
    input  logic                                        doneKey,
    input  logic                                        doneData,
    input  logic [BLOCK_WORDS-1:0][N-1:0]               outData
);

    arb_state_t                       r_state;
    arb_state_t                       w_state_next;
    logic                             r_last_grant;
    logic                             r_owner;
    logic                             r_cache_valid;
    logic [M-1:0][N-1:0]              r_key_cache;
    logic [M-1:0][N-1:0]              r_key;
    logic [BLOCK_WORDS-1:0][N-1:0]    r_block;
    logic                             r_enc_dec;
    logic [BLOCK_WORDS-1:0][N-1:0]    r_rsp_data;

    logic                             w_grant_valid;
    logic                             w_grant_idx;
    logic                             w_grant_fire;
    logic                             w_key_hit;

    simon_rr_picker u_picker (
        .i_req_valid   (reqValid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Cache comparison uses the incoming key because it is latched on this same edge.
    assign w_key_hit = r_cache_valid && (reqKey[w_grant_idx] == r_key_cache);

    always_comb begin
        w_state_next = r_state;
        w_grant_fire = 1'b0;
        newKey       = 1'b0;
        newData      = 1'b0;
        readData     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|reqValid) w_state_next = GRANT;
            end
            GRANT: begin
                if (w_grant_valid) begin
                    w_grant_fire = 1'b1;
                    w_state_next = w_key_hit ? DATA_REQ : KEY_REQ;
                end else begin
                    w_state_next = IDLE;
                end
            end
            KEY_REQ: begin
                newKey = 1'b1;
                if (loadKey) w_state_next = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (doneKey) w_state_next = DATA_REQ;
            end
            DATA_REQ: begin
                newData = 1'b1;
                if (loadData) w_state_next = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (doneData) w_state_next = RESP;
            end
            RESP: begin
                if (rspReady[r_owner]) begin
                    readData     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_cache_valid <= 1'b0;
            r_key_cache   <= '0;
            r_key         <= '0;
            r_block       <= '0;
            r_enc_dec     <= 1'b0;
            r_rsp_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_fire) begin
                r_owner   <= w_grant_idx;
                r_key     <= reqKey[w_grant_idx];
                r_block   <= reqBlock[w_grant_idx];
                r_enc_dec <= reqEncDec[w_grant_idx];
            end
            if (r_state == KEY_WAIT && doneKey) begin
                r_key_cache   <= r_key;
                r_cache_valid <= 1'b1;
            end
            if (r_state == DATA_WAIT && doneData) begin
                r_rsp_data <= outData;
            end
            if (readData) begin
                r_last_grant <= r_owner;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign reqAccept[gi] = (r_state == GRANT) && w_grant_valid && (w_grant_idx == 1'(gi));
            assign rspValid[gi]  = (r_state == RESP) && (r_owner == 1'(gi));
        end
    endgenerate

    // Core operands stay frozen from the grant until the next grant.
    assign KEY     = r_key;
    assign blockIN = r_block;
    assign enc_dec = r_enc_dec;
    assign rspData = r_rsp_data;

endmodule

// File: tb/tb_simon_arbiter.sv
// Directed bench for simon_arbiter with a behavioural SIMON32/64 core and a
// scoreboard of expected responses.
module tb_simon_arbiter;

    localparam int N = 16;
    localparam int M = 4;

    logic                   clk = 1'b0;
    logic                   R;
    logic [1:0]             reqValid;
    logic [1:0]             reqEncDec;
    logic [1:0][M-1:0][N-1:0] reqKey;
    logic [1:0][1:0][N-1:0] reqBlock;
    logic [1:0]             reqAccept;
    logic [1:0]             rspValid;
    logic [1:0]             rspReady;
    logic [1:0][N-1:0]      rspData;
    logic                   newKey, newData, enc_dec, readData;
    logic [M-1:0][N-1:0]    KEY;
    logic [1:0][N-1:0]      blockIN;
    logic                   loadKey = 1'b0, loadData = 1'b0, doneKey = 1'b0, doneData = 1'b0;
    logic [1:0][N-1:0]      outData = '0;

    always #5 clk = ~clk;

    simon_arbiter #(.N(N), .M(M)) dut (
        .clk(clk), .R(R),
        .reqValid(reqValid), .reqEncDec(reqEncDec), .reqKey(reqKey), .reqBlock(reqBlock),
        .reqAccept(reqAccept), .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .KEY(KEY), .blockIN(blockIN),
        .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey), .doneData(doneData),
        .outData(outData)
    );

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] simon_f(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] blk, input logic enc);
        logic [0:61] z;
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        z = 62'b11111_01000_10010_10110_00011_10011_01111_10100_01001_01011_00001_11001_10;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol(k[i-1], 13);
            t = t ^ k[i-3];
            t = t ^ rol(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'b0, z[i-4]} ^ 16'h0003;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (enc) begin
            for (int i = 0; i < 32; i++) begin
                t = x;
                x = y ^ simon_f(x) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y;
                y = x ^ simon_f(y) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    // Behavioural core: fixed handshake latencies, deliberately not cleared by R.
    int          kcnt = 0, dcnt = 0;
    logic [63:0] core_key = '0;
    logic [31:0] core_blk = '0;
    logic        core_enc = 1'b0;

    always @(posedge clk) begin
        loadKey  <= 1'b0;
        doneKey  <= 1'b0;
        loadData <= 1'b0;
        doneData <= 1'b0;
        if (kcnt == 0) begin
            if (newKey === 1'b1) kcnt <= 1;
        end else if (kcnt == 2) begin
            loadKey  <= 1'b1;
            core_key <= KEY;
            kcnt     <= 3;
        end else if (kcnt == 6) begin
            doneKey <= 1'b1;
            kcnt    <= 0;
        end else begin
            kcnt <= kcnt + 1;
        end
        if (dcnt == 0) begin
            if (newData === 1'b1) dcnt <= 1;
        end else if (dcnt == 2) begin
            loadData <= 1'b1;
            core_blk <= blockIN;
            core_enc <= enc_dec;
            dcnt     <= 3;
        end else if (dcnt == 9) begin
            doneData <= 1'b1;
            outData  <= simon_ref(core_key, core_blk, core_enc);
            dcnt     <= 0;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    int   nk_bursts = 0, nd_bursts = 0;
    logic nk_d = 1'b0, nd_d = 1'b0;
    always @(posedge clk) begin
        nk_d <= newKey;
        nd_d <= newData;
        if (newKey === 1'b1 && nk_d !== 1'b1) nk_bursts <= nk_bursts + 1;
        if (newData === 1'b1 && nd_d !== 1'b1) nd_bursts <= nd_bursts + 1;
    end

    typedef struct packed {
        logic [1:0]  owner;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [63:0] key, input logic [31:0] blk, input logic enc);
        reqKey[idx]    = key;
        reqBlock[idx]  = blk;
        reqEncDec[idx] = enc;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] data);
        exp_t e;
        e.owner = (idx == 0) ? 2'b01 : 2'b10;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_accept(input logic [1:0] exp_acc, input string tag);
        int cyc = 0;
        @(negedge clk);
        while (reqAccept == 2'b00 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_accept"}, 64'(reqAccept), 64'(exp_acc));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_response(input int hold, input string tag);
        int          cyc = 0;
        exp_t        e;
        logic [31:0] held;
        @(negedge clk);
        while (rspValid == 2'b00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
        chk({tag, "_owner"}, 64'(rspValid), 64'(e.owner));
        chk({tag, "_data"}, 64'(rspData), 64'(e.data));
        $display("rsp %s owner=%b data=0x%08h expected=0x%08h", tag, rspValid, rspData, e.data);
        held = rspData;
        for (int i = 0; i < hold; i++) begin
            rspReady = ~e.owner;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(rspValid), 64'(e.owner));
            chk({tag, "_hold_data"}, 64'(rspData), 64'(held));
            chk({tag, "_hold_readdata"}, 64'(readData), 64'(0));
        end
        rspReady = e.owner;
        #1;
        chk({tag, "_readdata"}, 64'(readData), 64'(1));
        @(posedge clk);
        #1;
        rspReady = 2'b00;
        @(negedge clk);
        chk({tag, "_released"}, 64'(rspValid), 64'(0));
    endtask

    localparam logic [63:0] KT = 64'h1918_1110_0908_0100;
    localparam logic [63:0] K1 = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] K5 = 64'hdead_beef_0bad_f00d;
    localparam logic [63:0] K6 = 64'h5555_aaaa_3333_cccc;
    localparam logic [63:0] K7 = 64'h0f0f_f0f0_1234_8765;
    localparam logic [63:0] K8 = 64'h7777_1111_9999_eeee;

    initial begin
        int   nk0, nd0, cyc;
        logic seen;
        R = 1'b1; reqValid = '0; reqEncDec = '0; reqKey = '0; reqBlock = '0; rspReady = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_accept", 64'(reqAccept), 64'(0));
        chk("rst_rspvalid", 64'(rspValid), 64'(0));
        chk("rst_newkey", 64'(newKey), 64'(0));
        chk("rst_newdata", 64'(newData), 64'(0));
        chk("rst_readdata", 64'(readData), 64'(0));
        chk("rst_rspdata", 64'(rspData), 64'(0));
        @(posedge clk); #1;
        R = 1'b0;

        // Simultaneous requests: requester 0 first, on the second cycle.
        set_req(0, KT, 32'h6565_6877, 1'b1);
        set_req(1, K1, 32'h1357_9bdf, 1'b0);
        push_exp(0, 32'hc69b_e9bb);
        push_exp(1, simon_ref(K1, 32'h1357_9bdf, 1'b0));
        reqValid = 2'b11;
        @(negedge clk);
        chk("s1_idle_accept", 64'(reqAccept), 64'(0));
        @(negedge clk);
        chk("s1_grant_accept", 64'(reqAccept), 64'(2'b01));
        @(posedge clk); #1;
        reqValid = 2'b10;
        wait_response(0, "s1_req0");
        wait_accept(2'b10, "s1_req1");
        reqValid = 2'b00;
        wait_response(0, "s1_req1");

        // Same key twice: one key load, two data loads.
        nk0 = nk_bursts; nd0 = nd_bursts;
        set_req(0, K5, 32'hcafe_0001, 1'b1);
        push_exp(0, simon_ref(K5, 32'hcafe_0001, 1'b1));
        reqValid = 2'b01;
        wait_accept(2'b01, "s2_job0");
        reqValid = 2'b00;
        wait_response(0, "s2_job0");
        set_req(1, K5, 32'hbeef_0002, 1'b0);
        push_exp(1, simon_ref(K5, 32'hbeef_0002, 1'b0));
        reqValid = 2'b10;
        wait_accept(2'b10, "s2_job1");
        reqValid = 2'b00;
        wait_response(0, "s2_job1");
        chk("s2_newkey_bursts", 64'(nk_bursts - nk0), 64'(1));
        chk("s2_newdata_bursts", 64'(nd_bursts - nd0), 64'(2));

        // Long back-pressure with the other requester's rspReady asserted.
        nk0 = nk_bursts;
        set_req(1, K5, 32'h0000_ffff, 1'b1);
        push_exp(1, simon_ref(K5, 32'h0000_ffff, 1'b1));
        reqValid = 2'b10;
        wait_accept(2'b10, "s3_hold");
        reqValid = 2'b00;
        wait_response(20, "s3_hold");
        chk("s3_cached_newkey", 64'(nk_bursts - nk0), 64'(0));

        // Reset while the core is busy on the data phase.
        set_req(0, K6, 32'h2468_ace0, 1'b1);
        reqValid = 2'b01;
        wait_accept(2'b01, "s4_aborted");
        reqValid = 2'b00;
        cyc = 0;
        @(negedge clk);
        while (loadData !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("s4_reach_loaddata", 64'(loadData), 64'(1));
        @(posedge clk);
        @(posedge clk); #1;
        R = 1'b1;
        @(posedge clk); #1;
        R = 1'b0;
        @(negedge clk);
        chk("s4_rspdata_cleared", 64'(rspData), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen = seen | (|rspValid);
        end
        chk("s4_no_rspvalid", 64'(seen), 64'(0));
        nk0 = nk_bursts;
        set_req(0, K6, 32'h2468_ace0, 1'b1);
        push_exp(0, simon_ref(K6, 32'h2468_ace0, 1'b1));
        reqValid = 2'b01;
        wait_accept(2'b01, "s4_retry");
        reqValid = 2'b00;
        wait_response(0, "s4_retry");
        chk("s4_key_reloaded", 64'(nk_bursts - nk0), 64'(1));

        // Continuous requests with different keys alternate 0,1,0,1.
        @(posedge clk); #1;
        R = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        R = 1'b0;
        nk0 = nk_bursts;
        set_req(0, K7, 32'h1111_2222, 1'b1);
        set_req(1, K8, 32'h3333_4444, 1'b0);
        reqValid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(0, simon_ref(K7, 32'h1111_2222, 1'b1));
            else            push_exp(1, simon_ref(K8, 32'h3333_4444, 1'b0));
            wait_accept((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("s5_job%0d", i));
            if (i == 3) reqValid = 2'b00;
            wait_response(0, $sformatf("s5_job%0d", i));
        end
        chk("s5_newkey_bursts", 64'(nk_bursts - nk0), 64'(4));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | (|reqAccept);
        end
        chk("s5_quiet_after", 64'(seen), 64'(0));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
